// File: rtl/input_pingpong_buffer_pkg.sv
// Shared definitions for the ping-pong input buffer.
//   NUM_BANKS    : number of banks that alternate between writer and reader.
//   word_width() : packed word width for a channel count and sample width.
//   len_width()  : width of a bank length counter (1..DEPTH needs one extra bit).
//   rd_status_e  : encoding of the registered read response.
package input_buffer_pkg;

  localparam int NUM_BANKS = 2;

  function automatic int word_width(input int num_ch, input int data_width);
    return num_ch * data_width;
  endfunction

  function automatic int len_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Status of the read response presented in the cycle after rd_en.
  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_OK   = 2'b01,
    RD_ERR  = 2'b10
  } rd_status_e;

endpackage

// File: rtl/input_pingpong_buffer_if.sv
// Bus bundle between the stream source / compute reader and the buffer.
//   master : stream source and compute reader (drives wr_*, rd_en, rd_addr, rd_release).
//   slave  : the buffer (drives wr_ready, read status/data, flags, debug selects).
//
// Handshake: a write word transfers on a rising clk edge where wr_valid && wr_ready;
// the source must hold wr_data/wr_last stable while wr_valid is high and wr_ready is
// low. Reads have no handshake: rd_en is sampled every edge and the response
// (rd_data_valid or rd_err) appears exactly one cycle later.
interface input_pingpong_buffer_if
  import input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CH     = 4
);
  localparam int W  = word_width(NUM_CH, DATA_WIDTH);
  localparam int LW = len_width(ADDR_WIDTH);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [W-1:0]          wr_data;
  logic                  wr_last;
  logic                  rd_bank_valid;
  logic [LW-1:0]         rd_len;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [W-1:0]          rd_data;
  logic                  rd_data_valid;
  logic                  rd_release;
  logic                  rd_err;
  logic [NUM_BANKS-1:0]  bank_full;
  // Debug visibility of the bank selects.
  logic                  dbg_wr_sel;
  logic                  dbg_rd_sel;

  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_bank_valid, rd_len, rd_data, rd_data_valid, rd_err,
           bank_full, dbg_wr_sel, dbg_rd_sel
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
    output wr_ready, rd_bank_valid, rd_len, rd_data, rd_data_valid, rd_err,
           bank_full, dbg_wr_sel, dbg_rd_sel
  );

endinterface

// File: rtl/input_pingpong_buffer_bank_ram.sv
// ib_bank_ram: simple dual-port RAM, one write port and one registered read port.
// Both banks share one array; the bank select is the address MSB.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data; holds its value when re is low
module ib_bank_ram
  import input_buffer_pkg::*;
#(
  parameter int W  = 64,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [0:(1<<AW)-1];
  logic [W-1:0] rdata_q;

  // No reset on the array or output register so the block maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/input_pingpong_buffer.sv
// input_pingpong_buffer: two-bank input buffer. The writer fills bank wr_sel through
// the valid/ready handshake; the reader randomly reads bank rd_sel once it is full.
// A bank closes on wr_last or when its last address is written.
//   clk : clock
//   rst : asynchronous active-high reset (RAM contents are kept)
//   bus : slave side of input_pingpong_buffer_if (write stream, read port, flags)
module input_pingpong_buffer
  import input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input_pingpong_buffer_if.slave  bus
);

  localparam int W  = word_width(NUM_CH, DATA_WIDTH);
  localparam int LW = len_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic                          wr_sel_q, wr_sel_d;
  logic                          rd_sel_q, rd_sel_d;
  logic [ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [NUM_BANKS-1:0]          bank_full_q, bank_full_d;
  logic [NUM_BANKS-1:0][LW-1:0]  bank_len_q, bank_len_d;
  rd_status_e                    rd_status_q, rd_status_d;
  // Forces rd_data to zero after reset and after an illegal read, until the next
  // legal read reloads the RAM output register.
  logic                          rd_zero_q, rd_zero_d;

  logic          wr_ready, wr_fire, wr_close;
  logic          rd_bank_valid, rd_legal, rd_illegal, rel_fire;
  logic [LW-1:0] rd_len;
  logic [W-1:0]  ram_rdata;

  always_comb begin
    wr_ready      = !rst && !bank_full_q[wr_sel_q];
    wr_fire       = bus.wr_valid && wr_ready;
    wr_close      = wr_fire && (bus.wr_last || (wr_ptr_q == LAST_ADDR));
    rd_bank_valid = bank_full_q[rd_sel_q];
    rd_len        = bank_len_q[rd_sel_q];
    rd_legal      = bus.rd_en && rd_bank_valid && ({1'b0, bus.rd_addr} < rd_len);
    rd_illegal    = bus.rd_en && !rd_legal;
    rel_fire      = bus.rd_release && rd_bank_valid;
  end

  always_comb begin
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_ptr_d    = wr_ptr_q;
    bank_full_d = bank_full_q;
    bank_len_d  = bank_len_q;
    rd_status_d = RD_IDLE;
    rd_zero_d   = rd_zero_q;

    if (wr_fire) begin
      if (wr_close) begin
        bank_full_d[wr_sel_q] = 1'b1;
        bank_len_d[wr_sel_q]  = LW'(wr_ptr_q) + LW'(1);
        wr_ptr_d              = '0;
        wr_sel_d              = !wr_sel_q;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
    end

    // The writer can never close the bank being released: that bank is full,
    // so wr_ready is low while wr_sel points at it.
    if (rel_fire) begin
      bank_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = !rd_sel_q;
    end

    if (rd_legal) begin
      rd_status_d = RD_OK;
      rd_zero_d   = 1'b0;
    end else if (rd_illegal) begin
      rd_status_d = RD_ERR;
      rd_zero_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_ptr_q    <= '0;
      bank_full_q <= '0;
      bank_len_q  <= '0;
      rd_status_q <= RD_IDLE;
      rd_zero_q   <= 1'b1;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      bank_full_q <= bank_full_d;
      bank_len_q  <= bank_len_d;
      rd_status_q <= rd_status_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  ib_bank_ram #(.W(W), .AW(ADDR_WIDTH + 1)) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wr_sel_q, wr_ptr_q}),
    .wdata (bus.wr_data),
    .re    (rd_legal),
    .raddr ({rd_sel_q, bus.rd_addr}),
    .rdata (ram_rdata)
  );

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.rd_len        = rd_len;
  assign bus.rd_data       = rd_zero_q ? '0 : ram_rdata;
  assign bus.rd_data_valid = (rd_status_q == RD_OK);
  assign bus.rd_err        = (rd_status_q == RD_ERR);
  assign bus.bank_full     = bank_full_q;
  assign bus.dbg_wr_sel    = wr_sel_q;
  assign bus.dbg_rd_sel    = rd_sel_q;

endmodule

// File: tb/tb_input_pingpong_buffer.sv
// Directed bench for input_pingpong_buffer with NUM_CH=2, DATA_WIDTH=8, ADDR_WIDTH=2.
module tb_input_pingpong_buffer;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NC = 2;
  localparam int W  = NC * DW;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  input_pingpong_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();

  input_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs are
  // sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.wr_last    = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_release = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    while (!bus.wr_ready && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_timeout data=%h wr_ready=%b required=1", d, bus.wr_ready);
    end
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    step();
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_release();
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
  endtask

  task automatic test_reset();
    step();
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b exp=0", bus.wr_ready); end
    total++; if (bus.bank_full !== 2'b00) begin bad++; $display("FAIL rst_bank_full got=%b exp=00", bus.bank_full); end
    total++; if (bus.rd_data_valid !== 1'b0 || bus.rd_err !== 1'b0) begin bad++; $display("FAIL rst_rd_flags got=%b%b exp=00", bus.rd_data_valid, bus.rd_err); end
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL rst_rd_data got=%h exp=0000", bus.rd_data); end
    total++; if (bus.rd_bank_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_bank_valid got=%b exp=0", bus.rd_bank_valid); end
    rst = 1'b0;
    step();
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_release_wr_ready got=%b exp=1", bus.wr_ready); end
  endtask

  task automatic test_full_fill();
    logic [W-1:0] words [4];
    words[0] = 16'h0100; words[1] = 16'h0302; words[2] = 16'h0504; words[3] = 16'h0706;
    for (int i = 0; i < 4; i++) begin
      write_word(words[i], 1'b0);
      exp_q.push_back(words[i]);
    end
    total++; if (bus.bank_full !== 2'b01) begin bad++; $display("FAIL fill_bank_full got=%b exp=01", bus.bank_full); end
    total++; if (bus.rd_len !== 3'd4) begin bad++; $display("FAIL fill_rd_len got=%0d exp=4", bus.rd_len); end
    total++; if (bus.rd_bank_valid !== 1'b1) begin bad++; $display("FAIL fill_rd_bank_valid got=%b exp=1", bus.rd_bank_valid); end
    total++; if (bus.dbg_wr_sel !== 1'b1) begin bad++; $display("FAIL fill_wr_sel got=%b exp=1", bus.dbg_wr_sel); end
    for (int i = 0; i < 4; i++) begin
      do_read(AW'(i));
      exp_w = exp_q.pop_front();
      total++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== exp_w) begin bad++; $display("FAIL fill_read%0d got=%h/v%b exp=%h/v1", i, bus.rd_data, bus.rd_data_valid, exp_w); end
    end
    step();
    total++; if (bus.rd_data_valid !== 1'b0 || bus.rd_data !== 16'h0706) begin bad++; $display("FAIL fill_hold got=%h/v%b exp=0706/v0", bus.rd_data, bus.rd_data_valid); end
    do_release();
    total++; if (bus.bank_full !== 2'b00 || bus.dbg_rd_sel !== 1'b1) begin bad++; $display("FAIL fill_release got=%b/sel%b exp=00/sel1", bus.bank_full, bus.dbg_rd_sel); end
  endtask

  task automatic test_short_frame();
    write_word(16'hAA55, 1'b1);
    total++; if (bus.bank_full !== 2'b10 || bus.rd_len !== 3'd1) begin bad++; $display("FAIL short_close got=%b/len%0d exp=10/len1", bus.bank_full, bus.rd_len); end
    do_read(2'd1);
    total++; if (bus.rd_err !== 1'b1 || bus.rd_data !== 16'h0000 || bus.rd_data_valid !== 1'b0) begin bad++; $display("FAIL short_err got=err%b/%h/v%b exp=err1/0000/v0", bus.rd_err, bus.rd_data, bus.rd_data_valid); end
    step();
    total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%b exp=0", bus.rd_err); end
    do_read(2'd0);
    total++; if (bus.rd_data !== 16'hAA55 || bus.rd_data_valid !== 1'b1) begin bad++; $display("FAIL short_read got=%h/v%b exp=aa55/v1", bus.rd_data, bus.rd_data_valid); end
    do_release();
    total++; if (bus.bank_full !== 2'b00 || bus.dbg_rd_sel !== 1'b0 || bus.dbg_wr_sel !== 1'b0) begin bad++; $display("FAIL short_release got=%b/r%b/w%b exp=00/r0/w0", bus.bank_full, bus.dbg_rd_sel, bus.dbg_wr_sel); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) write_word(16'h1000 + W'(i), 1'b0);
    for (int i = 0; i < 4; i++) write_word(16'h2000 + W'(i), 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hBEEF;
    total++; if (bus.bank_full !== 2'b11 || bus.wr_ready !== 1'b0) begin bad++; $display("FAIL bp_both_full got=%b/rdy%b exp=11/rdy0", bus.bank_full, bus.wr_ready); end
    for (int i = 0; i < 3; i++) step();
    total++; if (bus.wr_ready !== 1'b0 || bus.bank_full !== 2'b11 || bus.dbg_wr_sel !== 1'b0) begin bad++; $display("FAIL bp_stall got=rdy%b/%b/w%b exp=rdy0/11/w0", bus.wr_ready, bus.bank_full, bus.dbg_wr_sel); end
    do_release();
    total++; if (bus.wr_ready !== 1'b1 || bus.bank_full !== 2'b10 || bus.dbg_rd_sel !== 1'b1) begin bad++; $display("FAIL bp_freed got=rdy%b/%b/r%b exp=rdy1/10/r1", bus.wr_ready, bus.bank_full, bus.dbg_rd_sel); end
    step();
    bus.wr_valid = 1'b0;
    write_word(16'h1111, 1'b0);
    write_word(16'h2222, 1'b0);
    write_word(16'h3333, 1'b0);
    total++; if (bus.bank_full !== 2'b11 || bus.dbg_wr_sel !== 1'b1) begin bad++; $display("FAIL bp_refill got=%b/w%b exp=11/w1", bus.bank_full, bus.dbg_wr_sel); end
    do_read(2'd3);
    total++; if (bus.rd_data !== 16'h2003 || bus.rd_data_valid !== 1'b1) begin bad++; $display("FAIL bp_bank1_read got=%h/v%b exp=2003/v1", bus.rd_data, bus.rd_data_valid); end
    do_release();
    do_read(2'd0);
    total++; if (bus.rd_data !== 16'hBEEF || bus.rd_data_valid !== 1'b1 || bus.rd_len !== 3'd4) begin bad++; $display("FAIL bp_beef_read got=%h/v%b/len%0d exp=beef/v1/len4", bus.rd_data, bus.rd_data_valid, bus.rd_len); end
  endtask

  task automatic test_simultaneous();
    write_word(16'h4000, 1'b0);
    write_word(16'h4001, 1'b0);
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 16'h4002;
    bus.wr_last    = 1'b1;
    bus.rd_en      = 1'b1;
    bus.rd_addr    = 2'd2;
    bus.rd_release = 1'b1;
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL sim_wr_ready got=%b exp=1", bus.wr_ready); end
    step();
    idle_inputs();
    total++; if (bus.rd_data !== 16'h2222 || bus.rd_data_valid !== 1'b1) begin bad++; $display("FAIL sim_read got=%h/v%b exp=2222/v1", bus.rd_data, bus.rd_data_valid); end
    total++; if (bus.dbg_rd_sel !== 1'b1 || bus.bank_full !== 2'b10 || bus.dbg_wr_sel !== 1'b0) begin bad++; $display("FAIL sim_flags got=r%b/%b/w%b exp=r1/10/w0", bus.dbg_rd_sel, bus.bank_full, bus.dbg_wr_sel); end
    total++; if (bus.rd_len !== 3'd3) begin bad++; $display("FAIL sim_rd_len got=%0d exp=3", bus.rd_len); end
    do_read(2'd2);
    total++; if (bus.rd_data !== 16'h4002 || bus.rd_data_valid !== 1'b1) begin bad++; $display("FAIL sim_bank1_read got=%h/v%b exp=4002/v1", bus.rd_data, bus.rd_data_valid); end
    do_release();
  endtask

  task automatic test_idle_read();
    total++; if (bus.bank_full !== 2'b00 || bus.dbg_rd_sel !== 1'b0) begin bad++; $display("FAIL idle_start got=%b/r%b exp=00/r0", bus.bank_full, bus.dbg_rd_sel); end
    do_read(2'd0);
    total++; if (bus.rd_err !== 1'b1 || bus.rd_data_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin bad++; $display("FAIL idle_err got=err%b/v%b/%h exp=err1/v0/0000", bus.rd_err, bus.rd_data_valid, bus.rd_data); end
    step();
    total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL idle_err_pulse got=%b exp=0", bus.rd_err); end
    do_release();
    total++; if (bus.bank_full !== 2'b00 || bus.dbg_rd_sel !== 1'b0 || bus.wr_ready !== 1'b1) begin bad++; $display("FAIL idle_release got=%b/r%b/rdy%b exp=00/r0/rdy1", bus.bank_full, bus.dbg_rd_sel, bus.wr_ready); end
  endtask

  task automatic test_reset_mid_fill();
    write_word(16'h6060, 1'b1);
    write_word(16'h5151, 1'b0);
    write_word(16'h5252, 1'b0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 2'd0;
    step();
    total++; if (bus.rd_data !== 16'h6060 || bus.rd_data_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_read got=%h/v%b exp=6060/v1", bus.rd_data, bus.rd_data_valid); end
    rst = 1'b1;
    #1;
    total++; if (bus.wr_ready !== 1'b0 || bus.bank_full !== 2'b00 || bus.rd_data_valid !== 1'b0) begin bad++; $display("FAIL rmid_in_reset got=rdy%b/%b/v%b exp=rdy0/00/v0", bus.wr_ready, bus.bank_full, bus.rd_data_valid); end
    step();
    total++; if (bus.rd_data !== 16'h0000 || bus.rd_data_valid !== 1'b0) begin bad++; $display("FAIL rmid_hold_reset got=%h/v%b exp=0000/v0", bus.rd_data, bus.rd_data_valid); end
    rst = 1'b0;
    bus.rd_en = 1'b0;
    step();
    total++; if (bus.rd_data_valid !== 1'b0 || bus.bank_full !== 2'b00 || bus.wr_ready !== 1'b1 || bus.dbg_wr_sel !== 1'b0) begin bad++; $display("FAIL rmid_after got=v%b/%b/rdy%b/w%b exp=v0/00/rdy1/w0", bus.rd_data_valid, bus.bank_full, bus.wr_ready, bus.dbg_wr_sel); end
    write_word(16'h7777, 1'b1);
    total++; if (bus.bank_full !== 2'b01 || bus.rd_len !== 3'd1) begin bad++; $display("FAIL rmid_new_frame got=%b/len%0d exp=01/len1", bus.bank_full, bus.rd_len); end
    do_read(2'd0);
    total++; if (bus.rd_data !== 16'h7777 || bus.rd_data_valid !== 1'b1) begin bad++; $display("FAIL rmid_read got=%h/v%b exp=7777/v1", bus.rd_data, bus.rd_data_valid); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_full_fill();
    test_short_frame();
    test_backpressure();
    test_simultaneous();
    test_idle_read();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_pingpong_buffer.md
Name: input_pingpong_buffer

Overview:
Multi-channel, double-banked (ping-pong) input buffer that sits between the input stream interface and the compute array. The writer fills one bank through a valid/ready handshake while the compute side randomly reads the other bank by address. Bank length is variable: a bank closes on `wr_last` or when it is full. It generalises the single-bank input buffer in channel count, depth and frame length.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- ADDR_WIDTH, 6, bank address width; DEPTH = 2**ADDR_WIDTH words per bank.
- NUM_CH, 4, channels packed per word; word width W = NUM_CH*DATA_WIDTH, with channel 0 in the LSBs.

Ports:
- clk  in  1  system clock; one clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  buffer can accept a word.
- wr_data  in  W  packed channel word.
- wr_last  in  1  qualifies the final word of a frame.
- rd_bank_valid  out  1  the current read bank holds a complete frame.
- rd_len  out  ADDR_WIDTH+1  word count of the current read bank (1..DEPTH).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  W  read data.
- rd_data_valid  out  1  rd_data is valid this cycle.
- rd_release  in  1  reader finished with the current bank.
- rd_err  out  1  one-cycle pulse on an illegal read.
- bank_full  out  2  per-bank full flags, for status and debug.

Behaviour:
- **State:**
  - wr_sel and rd_sel (1 bit each).
  - wr_ptr (ADDR_WIDTH bits).
  - bank_full[1:0].
  - bank_len[0..1] (ADDR_WIDTH+1 bits each).
- **Reset:**
  - All state is cleared to 0; rd_data, rd_data_valid and rd_err are 0.
  - wr_ready is 0 while rst is high.
  - RAM contents are not reset.
- **Write acceptance:**
  - wr_ready = !rst && !bank_full[wr_sel].
  - A word is accepted when wr_valid && wr_ready. It is written at [wr_sel][wr_ptr], then wr_ptr increments.
- **Bank close:** the accepted word closes the bank if wr_last=1 or wr_ptr==DEPTH-1. On close:
  - bank_full[wr_sel] <= 1.
  - bank_len[wr_sel] <= wr_ptr+1.
  - wr_ptr <= 0.
  - wr_sel toggles.
- **Read status:** rd_bank_valid = bank_full[rd_sel]; rd_len = bank_len[rd_sel].
- **Read latency:** exactly 1 cycle. A legal rd_en in cycle N gives rd_data and rd_data_valid=1 in cycle N+1. rd_data holds its value when there is no read.
- **Illegal read:** rd_en with !rd_bank_valid, or with rd_addr >= rd_len.
  - Next cycle: rd_err=1, rd_data_valid=0, rd_data=0.
  - No state changes.
- **Release:**
  - rd_release with rd_bank_valid clears bank_full[rd_sel] and toggles rd_sel at the clock edge.
  - rd_release without rd_bank_valid is ignored.
- **Read and release in the same cycle:** the read uses the pre-release rd_sel and returns normally.
- **Writer closes a bank while the reader releases the other, same cycle:** both updates apply.
- **Writer closes into the bank the reader is releasing, same cycle:** impossible, because wr_ready=0 while that bank is full. Freed-bank writes start the cycle after release.
- **Both banks full:** wr_ready=0 until a release. The writer stalls with no data loss; wr_data must be held by the source per valid/ready rules.
- **Reset mid-operation:**
  - A partially filled bank is discarded and full banks are dropped.
  - An in-flight read response is suppressed: rd_data_valid=0 on the cycle after reset deassert.
- **Sizing:** DEPTH=1 is legal; every word closes a bank.
- **Throughput:** sustained 1 word/cycle write and 1 read/cycle with no bubbles across bank swaps.

Decomposition:
- **Package `input_buffer_pkg`:**
  - NUM_BANKS=2.
  - Functions for word width and length width.
  - Error/status encodings.
- **Sub-module `ib_bank_ram`:**
  - Simple dual-port RAM with one write port and one registered read port, block-RAM inferable.
  - Instantiated twice, or once with a bank bit as the address MSB.
- **Top level:** pointers, flags, handshake and error logic.

Test Plan (NUM_CH=2, DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4):
1. **Full-bank fill:**
   - Stimulus: write 0x0100,0x0302,0x0504,0x0706 with no wr_last.
   - Required: bank_full=2'b01, rd_len=4, rd_bank_valid=1.
   - Then: reads of addr 0..3 return the same words, each 1 cycle later with rd_data_valid=1.
2. **Short frame:**
   - Stimulus: write 0xAA55 with wr_last=1.
   - Required: bank closes, rd_len=1.
   - Then: rd_addr=1 gives rd_err=1 and rd_data=0 next cycle; rd_addr=0 returns 0xAA55.
3. **Backpressure:**
   - Stimulus: fill both banks (4+4 words), with wr_valid held high on a 9th word 0xBEEF.
   - Required: wr_ready=0 and the word is not accepted.
   - Then: rd_release makes wr_ready=1 next cycle, and 0xBEEF is later read from bank 0 at addr 0.
4. **Simultaneous events:**
   - Stimulus: rd_en (addr 2) + rd_release in the same cycle the writer closes bank 1.
   - Required: the read returns old bank 0 word 2; afterwards rd_sel=1 and bank_full=2'b10.
5. **Idle read:**
   - Stimulus: rd_en with no full bank.
   - Required: rd_err pulse of exactly 1 cycle; rd_release is ignored; flags unchanged.
6. **Reset mid-fill:**
   - Stimulus: assert rst after 2 of 4 words, with a read pending.
   - Required: bank_full=0, rd_data_valid=0, wr_ready=0 during reset.
   - Then: after reset the next frame starts at bank 0 addr 0.
